// File: rtl/hazard_stall_if.sv
// Decode/memory-stage handshake bundle for hazard_stall_unit.
// master drives the ID/MEM status; slave (the stall unit) returns hazard, freeze and stall count.
interface hazard_stall_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r_en;
  logic             id_mem_w_en;
  logic             branch_taken;
  logic             mem_ready;
  logic             hazard;
  logic             freeze_if_id;
  logic             freeze_pipe;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, id_mem_w_en, branch_taken, mem_ready,
    input  hazard, freeze_if_id, freeze_pipe, stall_cycles
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, id_mem_w_en, branch_taken, mem_ready,
    output hazard, freeze_if_id, freeze_pipe, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// RAW / load-use hazard detection, memory-stall freeze and saturating stall counter.
// Macro FORWARDING_EN: when defined, only EXE-stage load-use dependencies raise hazard.
module hazard_stall_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_stall_if.slave bus
);

  typedef enum logic {RUN, MISS} state_t;

  // Shadow copies of the EXE and MEM pipeline slots
  logic             exe_v_q,    exe_v_d;
  logic [REG_W-1:0] exe_dest_q, exe_dest_d;
  logic             exe_wb_q,   exe_wb_d;
  logic             exe_ld_q,   exe_ld_d;
  logic             exe_st_q,   exe_st_d;
  logic             mem_v_q,    mem_v_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic             mem_wb_q,   mem_wb_d;
  logic             mem_op_q,   mem_op_d;
  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic hazard;
  logic freeze_pipe;
  logic freeze_if_id;
  logic issue;

  always_comb begin
`ifdef FORWARDING_EN
    hazard = bus.id_valid && exe_v_q && exe_ld_q && exe_wb_q &&
             ((exe_dest_q == bus.id_src1) ||
              (bus.id_two_src && (exe_dest_q == bus.id_src2)));
`else
    hazard = bus.id_valid &&
             ((exe_v_q && exe_wb_q && (exe_dest_q == bus.id_src1)) ||
              (mem_v_q && mem_wb_q && (mem_dest_q == bus.id_src1)) ||
              (bus.id_two_src &&
               ((exe_v_q && exe_wb_q && (exe_dest_q == bus.id_src2)) ||
                (mem_v_q && mem_wb_q && (mem_dest_q == bus.id_src2)))));
`endif
    freeze_pipe  = mem_v_q && mem_op_q && !bus.mem_ready;
    freeze_if_id = hazard || freeze_pipe;
    issue        = bus.id_valid && !hazard && !bus.branch_taken;
  end

  always_comb begin
    exe_v_d    = exe_v_q;
    exe_dest_d = exe_dest_q;
    exe_wb_d   = exe_wb_q;
    exe_ld_d   = exe_ld_q;
    exe_st_d   = exe_st_q;
    mem_v_d    = mem_v_q;
    mem_dest_d = mem_dest_q;
    mem_wb_d   = mem_wb_q;
    mem_op_d   = mem_op_q;
    if (!freeze_pipe) begin
      mem_v_d    = exe_v_q;
      mem_dest_d = exe_dest_q;
      mem_wb_d   = exe_wb_q;
      mem_op_d   = exe_ld_q || exe_st_q;
      // hazard or a taken branch turns the ID slot into a bubble
      exe_v_d    = issue;
      exe_dest_d = bus.id_dest;
      exe_wb_d   = bus.id_wb_en;
      exe_ld_d   = bus.id_mem_r_en;
      exe_st_d   = bus.id_mem_w_en;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (freeze_pipe)   state_d = MISS;
      MISS:    if (bus.mem_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
    cnt_d = cnt_q;
    if (freeze_if_id && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_v_q    <= 1'b0;
      exe_dest_q <= '0;
      exe_wb_q   <= 1'b0;
      exe_ld_q   <= 1'b0;
      exe_st_q   <= 1'b0;
      mem_v_q    <= 1'b0;
      mem_dest_q <= '0;
      mem_wb_q   <= 1'b0;
      mem_op_q   <= 1'b0;
      state_q    <= RUN;
      cnt_q      <= '0;
    end else begin
      exe_v_q    <= exe_v_d;
      exe_dest_q <= exe_dest_d;
      exe_wb_q   <= exe_wb_d;
      exe_ld_q   <= exe_ld_d;
      exe_st_q   <= exe_st_d;
      mem_v_q    <= mem_v_d;
      mem_dest_q <= mem_dest_d;
      mem_wb_q   <= mem_wb_d;
      mem_op_q   <= mem_op_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.hazard       = hazard;
  assign bus.freeze_if_id = freeze_if_id;
  assign bus.freeze_pipe  = freeze_pipe;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit against a queue-based in-flight model.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_if #(.REG_W(4), .CNT_W(16)) bus ();
  hazard_stall_if #(.REG_W(4), .CNT_W(4))  sbus ();

  hazard_stall_unit #(.REG_W(4), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_stall_unit #(.REG_W(4), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(sbus));

  assign sbus.id_valid     = bus.id_valid;
  assign sbus.id_src1      = bus.id_src1;
  assign sbus.id_src2      = bus.id_src2;
  assign sbus.id_two_src   = bus.id_two_src;
  assign sbus.id_wb_en     = bus.id_wb_en;
  assign sbus.id_dest      = bus.id_dest;
  assign sbus.id_mem_r_en  = bus.id_mem_r_en;
  assign sbus.id_mem_w_en  = bus.id_mem_w_en;
  assign sbus.branch_taken = bus.branch_taken;
  assign sbus.mem_ready    = bus.mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: in-flight instructions, youngest first; entry 0 sits in EXE, entry 1 in MEM.
  typedef struct {bit v; int dest; bit wb; bit ld; bit mem;} ent_t;
  ent_t        infl[$];
  longint      stalls;
  bit          mdl_ok = 0;

  function automatic void mdl_reset();
    ent_t b = '{default: 0};
    infl.delete();
    infl.push_back(b);
    infl.push_back(b);
    stalls = 0;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    bit hz, fp, v, two, wb, ld, st, br, r;
    int s1, s2, d;
    @(negedge clk);
    v = bus.id_valid; two = bus.id_two_src; wb = bus.id_wb_en;
    ld = bus.id_mem_r_en; st = bus.id_mem_w_en; br = bus.branch_taken; r = rst;
    s1 = int'(bus.id_src1); s2 = int'(bus.id_src2); d = int'(bus.id_dest);
    hz = 0;
    fp = 0;
    if (mdl_ok) begin
      for (int i = 0; i < 2; i++) begin
        bit dep;
        dep = infl[i].v && infl[i].wb && (infl[i].dest == s1 || (two && infl[i].dest == s2));
`ifdef FORWARDING_EN
        if (dep && i == 0 && infl[i].ld) hz = 1;
`else
        if (dep) hz = 1;
`endif
      end
      hz = hz && v;
      fp = infl[1].v && infl[1].mem && !bus.mem_ready;
      chk("hazard",       32'(bus.hazard),       32'(hz));
      chk("freeze_pipe",  32'(bus.freeze_pipe),  32'(fp));
      chk("freeze_if_id", 32'(bus.freeze_if_id), 32'(hz || fp));
      chk("stall16",      32'(bus.stall_cycles), 32'(sat(stalls, 16)));
      chk("stall4",       32'(sbus.stall_cycles), 32'(sat(stalls, 4)));
    end
    @(posedge clk);
    if (r) begin
      mdl_reset();
      mdl_ok = 1;
    end else if (mdl_ok) begin
      if (hz || fp) stalls++;
      if (!fp) begin
        ent_t n = '{default: 0};
        if (v && !hz && !br) n = '{1, d, wb, ld, ld || st};
        infl.push_front(n);
        void'(infl.pop_back());
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_two_src = 0;
    bus.id_wb_en = 0; bus.id_dest = 0; bus.id_mem_r_en = 0; bus.id_mem_w_en = 0;
    bus.branch_taken = 0; bus.mem_ready = 1;
  endtask

  task automatic ins(input int dst, input int a, input int b, input bit two,
                     input bit wb, input bit ld, input bit st);
    bus.id_valid = 1; bus.id_dest = 4'(dst); bus.id_src1 = 4'(a); bus.id_src2 = 4'(b);
    bus.id_two_src = two; bus.id_wb_en = wb; bus.id_mem_r_en = ld; bus.id_mem_w_en = st;
    bus.branch_taken = 0;
  endtask

  initial begin
    logic [31:0] base;
    idle();
    // reset with a live instruction in ID
    rst = 1;
    bus.id_valid = 1; bus.id_src1 = 4'd0; bus.id_wb_en = 1;
    step(); step();
    rst = 0;
    chk("rst_hazard", 32'(bus.hazard), 32'd0);
    chk("rst_fif",    32'(bus.freeze_if_id), 32'd0);
    chk("rst_fp",     32'(bus.freeze_pipe), 32'd0);
    chk("rst_cnt",    32'(bus.stall_cycles), 32'd0);

    // RAW chain: ADD R3 then SUB reading R3
    idle();
    base = 32'(bus.stall_cycles);
    ins(3, 1, 2, 1, 1, 0, 0); step();
    ins(4, 3, 5, 0, 1, 0, 0); step(); step(); step();
    idle(); step(); step();
`ifndef FORWARDING_EN
    chk("raw_stalls", 32'(bus.stall_cycles) - base, 32'd2);
`endif

    // load-use vs plain producer
    ins(5, 0, 0, 0, 1, 1, 0); step();
    ins(6, 1, 5, 1, 1, 0, 0); step(); step(); step();
    idle(); step(); step();
    ins(5, 0, 0, 0, 1, 0, 0); step();
    ins(6, 5, 0, 0, 1, 0, 0); step(); step(); step();
    idle(); step(); step();

    // cache miss: load reaches MEM, memory not ready for 4 cycles
    base = 32'(bus.stall_cycles);
    ins(7, 0, 0, 0, 1, 1, 0); step();
    idle(); step();
    bus.mem_ready = 0;
    repeat (4) step();
    bus.mem_ready = 1; step();
    chk("miss_stalls", 32'(bus.stall_cycles) - base, 32'd4);
    step(); step();

    // branch squash of a writer to R2, reader of R2 must not stall
    ins(2, 0, 0, 0, 1, 0, 0); bus.branch_taken = 1; step();
    ins(8, 2, 2, 1, 1, 0, 0); step();
    idle(); step(); step();

    // saturation: store-miss freeze of 20 cycles after a fresh reset
    rst = 1; step(); rst = 0;
    ins(0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    bus.mem_ready = 0;
    repeat (20) step();
    chk("sat4", 32'(sbus.stall_cycles), 32'd15);
    bus.mem_ready = 1; step();
    chk("sat4_hold", 32'(sbus.stall_cycles), 32'd15);

    // R15 destination behaves like any other
    idle(); step(); step();
    ins(15, 0, 0, 0, 1, 0, 0); step();
    ins(1, 15, 0, 0, 1, 0, 0); step(); step(); step();
    idle(); step(); step();

    // random traffic, small register range to force dependencies
    for (int c = 0; c < 600; c++) begin
      int rsel;
      rsel = $urandom_range(0, 9);
      rst = (rsel == 0) && ($urandom_range(0, 4) == 0);
      bus.id_valid     = ($urandom_range(0, 9) < 8);
      bus.id_src1      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      bus.id_src2      = 4'($urandom_range(0, 3));
      bus.id_two_src   = $urandom_range(0, 1);
      bus.id_dest      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      bus.id_mem_r_en  = ($urandom_range(0, 3) == 0);
      bus.id_mem_w_en  = !bus.id_mem_r_en && ($urandom_range(0, 6) == 0);
      bus.id_wb_en     = !bus.id_mem_w_en && ($urandom_range(0, 4) != 0);
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      bus.mem_ready    = ($urandom_range(0, 9) < 6);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Produces the bubble-select signal (`hazard`) that the decode-stage control unit uses to zero its control outputs.
- Produces the fetch/decode freeze and the whole-pipeline memory-stall freeze for the cached ARM pipeline.
- Keeps its own shadow scoreboard of in-flight destination registers (EXE and MEM stages), so RAW detection is self-contained.
- Counts stall cycles for performance debug.

Parameters:
- REG_W, 4, register index width.
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk  input  1  pipeline clock; reset is synchronous and active-high.
- rst  input  1  synchronous reset, active-high.
- id_valid  input  1  a real instruction is in ID.
- id_src1  input  REG_W  first source register (Rn).
- id_src2  input  REG_W  second source register (Rm/Rd for store).
- id_two_src  input  1  id_src2 is actually read.
- id_wb_en  input  1  ID instruction writes a register.
- id_dest  input  REG_W  ID destination register.
- id_mem_r_en  input  1  ID instruction is a load.
- id_mem_w_en  input  1  ID instruction is a store.
- branch_taken  input  1  EXE resolved a taken branch; squash ID.
- mem_ready  input  1  cache/memory completed the MEM-stage access this cycle.
- hazard  output  1  drives the control unit's bubble select.
- freeze_if_id  output  1  hold PC and the IF/ID register.
- freeze_pipe  output  1  hold all pipeline registers (memory stall).
- stall_cycles  output  CNT_W  saturating stall counter.

Behaviour:
- Shadow stages, each registered:
  - EXE slot: exe_v, exe_dest, exe_wb, exe_ld.
  - MEM slot: mem_v, mem_dest, mem_wb, mem_op (load or store).
- Reset (synchronous): all valid bits 0, state RUN, stall_cycles 0. Resulting outputs: hazard=0, freeze_if_id=0, freeze_pipe=0, stall_cycles=0.
- Advance, on a clock edge with freeze_pipe=0:
  - MEM slot <= EXE slot.
  - EXE slot <= ID fields if id_valid && !hazard && !branch_taken; otherwise a bubble (valid 0).
- With freeze_pipe=1, both slots hold their values.
- Match term: `match(s)` = slot valid && slot wb && slot dest == s.
- Hazard (combinational, FORWARDING_EN undefined): hazard = id_valid && (match_exe(src1) || match_mem(src1) || (id_two_src && (match_exe(src2) || match_mem(src2)))).
- Memory stall: freeze_pipe = mem_v && mem_op && !mem_ready (combinational, zero extra latency).
- freeze_if_id = hazard || freeze_pipe.
- FSM, two states:
  - RUN -> MISS when freeze_pipe=1.
  - MISS -> RUN on the edge where mem_ready=1; in that same cycle freeze_pipe=0 and the pipeline advances.
  - MISS with mem_ready=0 stays in MISS.
- stall_cycles: +1 on every edge with freeze_if_id=1; saturates at all-ones and never wraps.
- Simultaneous events:
  - branch_taken with hazard: the bubble is inserted and the ID instruction is squashed.
  - branch_taken or hazard during freeze_pipe: no state change.
  - Reset mid-MISS: returns to RUN, slots are cleared, and the pending access is abandoned.
- Dest R15 is tracked like any other register.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: the forwarding unit resolves all non-load RAW dependencies. hazard is asserted only on a load-use dependency:
  - hazard = id_valid && exe_v && exe_ld && exe_wb && (exe_dest==id_src1 || (id_two_src && exe_dest==id_src2)).
  - MEM-slot matches never stall.
- Undefined: full EXE+MEM RAW hazard as above.

Test Plan:
1. Reset: assert rst 2 cycles with id_valid=1 -> hazard=0, freeze_if_id=0, freeze_pipe=0, stall_cycles=0.
2. RAW, no forwarding: ADD R3 (wb, dest=3), then SUB with src1=3 next cycle -> hazard=1 for 2 cycles (EXE, then MEM match), ID instruction enters EXE on the third cycle, stall_cycles=2.
3. Load-use, FORWARDING_EN: LDR dest=5, then ADD src2=5 with two_src=1 -> hazard=1 for exactly 1 cycle. Non-load dest=5 followed by src=5 -> hazard=0.
4. Cache miss: LDR reaches MEM slot, mem_ready=0 for 4 cycles then 1 -> freeze_pipe=1 for 4 cycles, FSM MISS for 4 cycles, slots unchanged, advance on the fifth edge, stall_cycles +4.
5. Branch squash: branch_taken=1 with id_wb_en=1, dest=2; next ID reads R2 -> EXE slot bubble, no hazard for R2.
6. Saturation: CNT_W=4, hold hazard for 20 cycles -> stall_cycles reaches 15 and stays 15.
